branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch unit.
- Keeps execute-stage branch/jump resolution (PC+Imm, PC+4, redirect select).
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up at fetch.
- Flags mispredictions so the pipeline redirects and flushes. Sits between the fetch PC mux and the EX stage.

---
 rtl/branch_predict_unit.sv | 143 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a direct-mapped BTB of 2-bit saturating counters for fetch prediction.
// Optional performance counters are enabled by defining BPU_PERF_EN.
module branch_predict_unit #(
  parameter int         PC_W     = 9,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] F_PC,
  output logic            Pred_Taken,
  output logic [31:0]     Pred_Target,
  input  logic [PC_W-1:0] Cur_PC,
  input  logic [31:0]     Imm,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Jalr,
  input  logic [31:0]     AluResult,
  input  logic            Pred_Taken_Ex,
  input  logic [31:0]     Pred_Target_Ex,
  input  logic            flag_halt,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel,
  output logic            Flush,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mispred_Count
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic                 btb_valid  [DEPTH];
  logic [TAG_W-1:0]     btb_tag    [DEPTH];
  logic [1:0]           btb_ctr    [DEPTH];
  logic [PC_W-1:0]      btb_target [DEPTH];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             unused_fpc_bits;

  assign f_idx           = F_PC[IDX_W+1:2];
  assign f_tag           = F_PC[PC_W-1:IDX_W+2];
  assign f_hit           = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign Pred_Taken      = f_hit && btb_ctr[f_idx][1];
  assign Pred_Target     = Pred_Taken ? {{(32-PC_W){1'b0}}, btb_target[f_idx]} : 32'd0;
  assign unused_fpc_bits = ^F_PC[1:0];

  logic [31:0] cur_pc32;
  logic        ctl;
  logic        taken;
  logic [31:0] target;
  logic        mispredict;
  logic        update_en;

  assign cur_pc32  = {{(32-PC_W){1'b0}}, Cur_PC};
  assign PC_Imm    = cur_pc32 + Imm;
  assign PC_Four   = flag_halt ? 32'd0 : cur_pc32 + 32'd4;
  assign ctl       = Branch | Jump | Jalr;
  assign taken     = (Branch & AluResult[0]) | Jump | Jalr;
  assign target    = Jalr ? {AluResult[31:1], 1'b0} : PC_Imm;
  assign update_en = ctl & ~flag_halt;

  // A predicted-taken slot that turns out not to be a control instruction (stale alias)
  // falls out of the same comparison, since taken is 0 whenever ctl is 0.
  assign mispredict = ~flag_halt &
                      ((taken != Pred_Taken_Ex) | (taken & (Pred_Target_Ex != target)));

  assign PcSel = mispredict;
  assign Flush = mispredict;
  assign BrPC  = mispredict ? (taken ? target : PC_Four) : 32'd0;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;
  logic [1:0]       next_ctr;

  assign u_idx = Cur_PC[IDX_W+1:2];
  assign u_tag = Cur_PC[PC_W-1:IDX_W+2];
  assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
  assign u_ctr = btb_ctr[u_idx];

  always_comb begin
    next_ctr = u_ctr;
    if (Jalr || Jump) begin
      next_ctr = 2'b11;
    end else if (!u_hit) begin
      next_ctr = taken ? 2'b10 : 2'b01;
    end else if (taken) begin
      next_ctr = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
    end else begin
      next_ctr = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
    end
  end

  // Reset wins over a same-cycle update; lookups see updates only from the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_ctr[i]    <= CTR_INIT;
        btb_target[i] <= '0;
      end
    end else if (update_en) begin
      btb_valid[u_idx] <= 1'b1;
      btb_tag[u_idx]   <= u_tag;
      btb_ctr[u_idx]   <= next_ctr;
      if (!u_hit || taken) begin
        btb_target[u_idx] <= target[PC_W-1:0];
      end
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      if (update_en && (br_count_q != 32'hFFFF_FFFF)) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end
    end
  end

  assign Br_Count      = br_count_q;
  assign Mispred_Count = mispred_count_q;
`else
  assign Br_Count      = 32'd0;
  assign Mispred_Count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed test-plan steps followed by random
// traffic, all compared against a table model of the BTB and resolution rules.
module tb_branch_predict_unit;

  localparam int PC_W  = 9;
  localparam int IDX_W = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] F_PC;
  logic            Pred_Taken;
  logic [31:0]     Pred_Target;
  logic [PC_W-1:0] Cur_PC;
  logic [31:0]     Imm;
  logic            Branch;
  logic            Jump;
  logic            Jalr;
  logic [31:0]     AluResult;
  logic            Pred_Taken_Ex;
  logic [31:0]     Pred_Target_Ex;
  logic            flag_halt;
  logic [31:0]     PC_Imm;
  logic [31:0]     PC_Four;
  logic [31:0]     BrPC;
  logic            PcSel;
  logic            Flush;
  logic [31:0]     Br_Count;
  logic [31:0]     Mispred_Count;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_INIT(2'b01)) dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .Cur_PC(Cur_PC), .Imm(Imm), .Branch(Branch), .Jump(Jump), .Jalr(Jalr),
    .AluResult(AluResult), .Pred_Taken_Ex(Pred_Taken_Ex), .Pred_Target_Ex(Pred_Target_Ex),
    .flag_halt(flag_halt), .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel),
    .Flush(Flush), .Br_Count(Br_Count), .Mispred_Count(Mispred_Count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one record per BTB slot, counters held as plain integers 0..3.
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  int unsigned m_ctr   [DEPTH];
  int unsigned m_tgt   [DEPTH];
  int unsigned m_br;
  int unsigned m_mis;
  logic [31:0] last_brpc;
  logic        last_pcsel;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic void modelLookup(input int unsigned pc, output bit pt, output int unsigned ptg);
    int unsigned i;
    i   = (pc / 4) % DEPTH;
    pt  = m_valid[i] && (m_tag[i] == pc / 64) && (m_ctr[i] >= 2);
    ptg = pt ? m_tgt[i] : 0;
  endfunction

  // Drive one cycle of inputs, check all outputs mid-cycle, then clock and advance the model.
  task automatic applyStimulus(input logic rst, input logic [PC_W-1:0] fpc, input logic [PC_W-1:0] cpc,
                               input logic [31:0] imm, input logic [2:0] ctl_jjb, input logic [31:0] alu,
                               input logic pte, input logic [31:0] ptge, input logic halt);
    bit          e_pt, br, jp, jr, ctl, tk, mis, hit;
    int unsigned e_ptg, pc, e_pcimm, e_four, tg, e_brpc, i;
    reset = rst; F_PC = fpc; Cur_PC = cpc; Imm = imm;
    {Jalr, Jump, Branch} = ctl_jjb;
    AluResult = alu; Pred_Taken_Ex = pte; Pred_Target_Ex = ptge; flag_halt = halt;
    #1;
    modelLookup(fpc, e_pt, e_ptg);
    pc      = cpc;
    br      = ctl_jjb[0];
    jp      = ctl_jjb[1];
    jr      = ctl_jjb[2];
    ctl     = br || jp || jr;
    e_pcimm = pc + imm;
    e_four  = halt ? 0 : pc + 4;
    tk      = (br && alu[0]) || jp || jr;
    tg      = jr ? (alu & 32'hFFFF_FFFE) : e_pcimm;
    mis     = !halt && ((tk != pte) || (tk && ptge != tg));
    e_brpc  = mis ? (tk ? tg : e_four) : 0;
    last_brpc  = BrPC;
    last_pcsel = PcSel;
    checkOutput("pred_taken", {31'd0, Pred_Taken}, {31'd0, e_pt});
    checkOutput("pred_target", Pred_Target, e_ptg);
    checkOutput("pc_imm", PC_Imm, e_pcimm);
    checkOutput("pc_four", PC_Four, e_four);
    checkOutput("brpc", BrPC, e_brpc);
    checkOutput("pcsel", {31'd0, PcSel}, {31'd0, mis});
    checkOutput("flush", {31'd0, Flush}, {31'd0, mis});
`ifdef BPU_PERF_EN
    checkOutput("br_count", Br_Count, m_br);
    checkOutput("mispred_count", Mispred_Count, m_mis);
`else
    checkOutput("br_count", Br_Count, 32'd0);
    checkOutput("mispred_count", Mispred_Count, 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = 0;
      end
      m_br = 0; m_mis = 0;
    end else begin
      if (ctl && !halt) begin
        i   = (pc / 4) % DEPTH;
        hit = m_valid[i] && (m_tag[i] == pc / 64);
        if (!hit) begin
          m_valid[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tg % 512; m_ctr[i] = tk ? 2 : 1;
        end else begin
          if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = tg % 512;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end
        if (jp || jr) m_ctr[i] = 3;
        m_br++;
      end
      if (mis) m_mis++;
    end
    @(negedge clk);
  endtask

  task automatic peekLookup(input logic [PC_W-1:0] fpc, input string tag,
                            input logic exp_taken, input logic [31:0] exp_target);
    F_PC = fpc;
    #1;
    checkOutput({tag, "_taken"}, {31'd0, Pred_Taken}, {31'd0, exp_taken});
    checkOutput({tag, "_target"}, Pred_Target, exp_target);
  endtask

  initial begin
    bit          pt;
    int unsigned ptg;
    logic [PC_W-1:0] cpc;
    logic [2:0]  ctl;
    reset = 1'b1; F_PC = '0; Cur_PC = '0; Imm = '0; Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0;
    AluResult = '0; Pred_Taken_Ex = 1'b0; Pred_Target_Ex = '0; flag_halt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = 0;
    end
    m_br = 0; m_mis = 0;
    @(negedge clk);
    applyStimulus(1'b1, 9'h000, 9'h000, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b0, 9'h040, 9'h000, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0);
    // Taken branch at 0x40 -> 0x60, unpredicted.
    applyStimulus(1'b0, 9'h040, 9'h040, 32'h20, 3'b001, 32'h1, 1'b0, 32'h0, 1'b0);
    checkOutput("plan_brpc_0x60", last_brpc, 32'h60);
    peekLookup(9'h040, "plan_trained", 1'b1, 32'h60);
    // Three not-taken resolutions: 10 -> 01 -> 00 -> 00.
    applyStimulus(1'b0, 9'h040, 9'h040, 32'h20, 3'b001, 32'h0, 1'b1, 32'h60, 1'b0);
    checkOutput("plan_brpc_0x44", last_brpc, 32'h44);
    applyStimulus(1'b0, 9'h040, 9'h040, 32'h20, 3'b001, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 9'h040, 9'h040, 32'h20, 3'b001, 32'h0, 1'b0, 32'h0, 1'b0);
    peekLookup(9'h040, "plan_untrained", 1'b0, 32'h0);
    // One taken from 00 climbs only to 01, still predicting not-taken.
    applyStimulus(1'b0, 9'h040, 9'h040, 32'h20, 3'b001, 32'h1, 1'b0, 32'h0, 1'b0);
    peekLookup(9'h040, "plan_sat_floor", 1'b0, 32'h0);
    // JALR with wrong predicted target.
    applyStimulus(1'b0, 9'h010, 9'h010, 32'h0, 3'b100, 32'h85, 1'b1, 32'h80, 1'b0);
    checkOutput("plan_jalr_brpc", last_brpc, 32'h84);
    peekLookup(9'h010, "plan_jalr_entry", 1'b1, 32'h84);
    // Aliasing between 0x04 and 0x44.
    applyStimulus(1'b0, 9'h004, 9'h004, 32'h8, 3'b001, 32'h1, 1'b0, 32'h0, 1'b0);
    peekLookup(9'h004, "plan_alias_a", 1'b1, 32'h0C);
    applyStimulus(1'b0, 9'h044, 9'h044, 32'h10, 3'b001, 32'h1, 1'b0, 32'h0, 1'b0);
    peekLookup(9'h004, "plan_alias_evicted", 1'b0, 32'h0);
    peekLookup(9'h044, "plan_alias_b", 1'b1, 32'h54);
    // Halt blocks everything.
    applyStimulus(1'b0, 9'h044, 9'h044, 32'h30, 3'b001, 32'h1, 1'b0, 32'h0, 1'b1);
    checkOutput("plan_halt_pcsel", {31'd0, last_pcsel}, 32'd0);
    peekLookup(9'h044, "plan_halt_table", 1'b1, 32'h54);
    // Stale alias: predicted taken but not a control instruction.
    applyStimulus(1'b0, 9'h020, 9'h020, 32'h0, 3'b000, 32'h0, 1'b1, 32'h100, 1'b0);
    checkOutput("plan_stale_brpc", last_brpc, 32'h24);
    // All control bits at once: JALR wins.
    applyStimulus(1'b0, 9'h0C8, 9'h0C8, 32'h40, 3'b111, 32'h1F1, 1'b0, 32'h0, 1'b0);
    checkOutput("plan_multi_brpc", last_brpc, 32'h1F0);
    // Reset takes priority over a same-cycle update.
    applyStimulus(1'b1, 9'h0C8, 9'h07C, 32'h4, 3'b010, 32'h0, 1'b0, 32'h0, 1'b0);
    peekLookup(9'h07C, "plan_reset_prio", 1'b0, 32'h0);
    peekLookup(9'h044, "plan_reset_clear", 1'b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      cpc = PC_W'(($urandom_range(0, 3) * 64) + ($urandom_range(0, 3) * 4));
      if ($urandom_range(0, 7) == 0) cpc = PC_W'($urandom);
      modelLookup(cpc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom);
        ptg = $urandom_range(0, 511);
      end
      ctl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
      applyStimulus(($urandom_range(0, 99) == 0), PC_W'($urandom), cpc,
                    ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 63) * 4,
                    ctl, $urandom, pt, ptg, ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
